// File: rtl/free_list_pkg.sv
// Shared free-list/ROB packet definitions and geometry; pointer helpers wrap modulo NUM_FL.
package free_list_pkg;

  localparam int NUM_PR         = 64;
  localparam int NUM_ARCH_TABLE = 32;
  localparam int NUM_ROB        = 8;
  localparam int NUM_FL         = NUM_PR - NUM_ARCH_TABLE;

  localparam int PR_W  = $clog2(NUM_PR);
  localparam int FL_W  = $clog2(NUM_FL);
  localparam int ROB_W = $clog2(NUM_ROB);
  localparam int CNT_W = $clog2(NUM_FL + 1);

  // Field set mirrors ROB_PACKET_FREELIST_OUT.
  typedef struct packed {
    logic             retire_en;
    logic             retire_dest_valid;
    logic [PR_W-1:0]  T_old_idx_head;
    logic             rollback_en;
    logic [ROB_W-1:0] ROB_rollback_idx;
  } FREELIST_PACKET_IN;

  typedef struct packed {
    logic [PR_W-1:0] T_idx;
    logic            free_valid;
  } FREELIST_PACKET_OUT;

  function automatic logic [FL_W-1:0] fl_inc(input logic [FL_W-1:0] p);
    return (p == FL_W'(NUM_FL - 1)) ? '0 : p + FL_W'(1);
  endfunction

  // (a - b) mod NUM_FL
  function automatic logic [FL_W-1:0] fl_dist(input logic [FL_W-1:0] a, input logic [FL_W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = d + NUM_FL;
    return FL_W'(d);
  endfunction

endpackage

// File: rtl/fl_snapshot_table.sv
// Per-ROB-entry copy of the free-list head: one write port, one asynchronous read port.
module fl_snapshot_table
  import free_list_pkg::*;
#(
  parameter int DEPTH = NUM_ROB,
  parameter int WIDTH = FL_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_dat;
    end
  end

  assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/free_list.sv
// Circular list of free physical tags: pop on dispatch, push T_old on retire, head restore on rollback.
// Define FREELIST_DEBUG_EN to expose fl_dbg/head_dbg/tail_dbg and the push-on-full/pop-on-empty assertions.
module free_list
  import free_list_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             dispatch_en,
  input  logic             dest_valid,
  input  logic [ROB_W-1:0] ROB_tail_idx,
  input  logic             retire_en,
  input  logic             retire_dest_valid,
  input  logic [PR_W-1:0]  T_old_idx_head,
  input  logic             rollback_en,
  input  logic [ROB_W-1:0] ROB_rollback_idx,
  output logic [PR_W-1:0]  T_idx,
  output logic             free_valid,
  output logic [CNT_W-1:0] free_count
`ifdef FREELIST_DEBUG_EN
  ,
  output logic [NUM_FL-1:0][PR_W-1:0] fl_dbg,
  output logic [FL_W-1:0]             head_dbg,
  output logic [FL_W-1:0]             tail_dbg
`endif
);

  FREELIST_PACKET_IN  in_pkt;
  FREELIST_PACKET_OUT out_pkt;

  logic [PR_W-1:0]  fl [NUM_FL];
  logic [FL_W-1:0]  head;
  logic [FL_W-1:0]  tail;
  logic [FL_W-1:0]  head_pop;
  logic [FL_W-1:0]  snap_head;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             snap_wr;

  assign in_pkt.retire_en         = retire_en;
  assign in_pkt.retire_dest_valid = retire_dest_valid;
  assign in_pkt.T_old_idx_head    = T_old_idx_head;
  assign in_pkt.rollback_en       = rollback_en;
  assign in_pkt.ROB_rollback_idx  = ROB_rollback_idx;

  assign out_pkt.T_idx      = fl[head];
  assign out_pkt.free_valid = (count != '0);

  assign T_idx      = out_pkt.T_idx;
  assign free_valid = out_pkt.free_valid;
  assign free_count = count;

  // A tag pushed this cycle is never forwarded: free_valid reflects registered count only.
  assign pop      = en & dispatch_en & dest_valid & out_pkt.free_valid & ~in_pkt.rollback_en;
  assign push     = en & in_pkt.retire_en & in_pkt.retire_dest_valid;
  assign snap_wr  = en & dispatch_en & ~in_pkt.rollback_en;
  assign head_pop = pop ? fl_inc(head) : head;

  fl_snapshot_table #(
    .DEPTH (NUM_ROB),
    .WIDTH (FL_W)
  ) u_snap (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (snap_wr),
    .wr_idx (ROB_tail_idx),
    .wr_dat (head_pop),
    .rd_idx (in_pkt.ROB_rollback_idx),
    .rd_dat (snap_head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_FL; i++) fl[i] <= PR_W'(NUM_ARCH_TABLE + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(NUM_FL);
    end else if (en) begin
      if (push) begin
        fl[tail] <= in_pkt.T_old_idx_head;
        tail     <= fl_inc(tail);
      end
      // Tags popped since the snapshot lie between snap_head and head; restoring head returns them.
      if (in_pkt.rollback_en) begin
        head  <= snap_head;
        count <= count + CNT_W'(fl_dist(head, snap_head)) + CNT_W'(push);
      end else begin
        head  <= head_pop;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

`ifdef FREELIST_DEBUG_EN
  for (genvar g = 0; g < NUM_FL; g++) begin : g_dbg
    assign fl_dbg[g] = fl[g];
  end
  assign head_dbg = head;
  assign tail_dbg = tail;

  a_push_full: assert property (@(posedge clock) disable iff (!reset) push |-> (count != CNT_W'(NUM_FL)));
  a_pop_empty: assert property (@(posedge clock) disable iff (!reset) pop |-> (count != '0));
`endif

endmodule

// File: tb/tb_free_list.sv
// Directed bench: stimulus queues expected outputs per cycle, a negedge monitor pops and compares.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       dispatch_en = 1'b0;
  logic       dest_valid = 1'b0;
  logic [2:0] ROB_tail_idx = '0;
  logic       retire_en = 1'b0;
  logic       retire_dest_valid = 1'b0;
  logic [5:0] T_old_idx_head = '0;
  logic       rollback_en = 1'b0;
  logic [2:0] ROB_rollback_idx = '0;
  logic [5:0] T_idx;
  logic       free_valid;
  logic [5:0] free_count;

  free_list dut (
    .clock             (clock),
    .reset             (reset),
    .en                (en),
    .dispatch_en       (dispatch_en),
    .dest_valid        (dest_valid),
    .ROB_tail_idx      (ROB_tail_idx),
    .retire_en         (retire_en),
    .retire_dest_valid (retire_dest_valid),
    .T_old_idx_head    (T_old_idx_head),
    .rollback_en       (rollback_en),
    .ROB_rollback_idx  (ROB_rollback_idx),
    .T_idx             (T_idx),
    .free_valid        (free_valid),
    .free_count        (free_count)
  );

  always #5 clock = ~clock;

  // mask bit0: T_idx, bit1: free_valid, bit2: free_count
  typedef struct {
    string      nm;
    logic [2:0] m;
    logic [5:0] t;
    logic       v;
    logic [5:0] c;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input string field, input logic [5:0] act, input logic [5:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s.%s: got %0d, expected %0d", nm, field, act, req);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      if (cur.m[0]) chk(cur.nm, "T_idx", T_idx, cur.t);
      if (cur.m[1]) chk(cur.nm, "free_valid", {5'd0, free_valid}, {5'd0, cur.v});
      if (cur.m[2]) chk(cur.nm, "free_count", free_count, cur.c);
    end
  end

  task automatic step(input logic e, input logic d, input logic dv, input logic [2:0] rt,
                      input logic r, input logic [5:0] told, input logic rb, input logic [2:0] rbi);
    @(posedge clock);
    #1;
    en                = e;
    dispatch_en       = d;
    dest_valid        = dv;
    ROB_tail_idx      = rt;
    retire_en         = r;
    retire_dest_valid = r;
    T_old_idx_head    = told;
    rollback_en       = rb;
    ROB_rollback_idx  = rbi;
  endtask

  task automatic expect_out(input string nm, input logic [2:0] m, input logic [5:0] t,
                            input logic v, input logic [5:0] c);
    exp_t e;
    e.nm = nm; e.m = m; e.t = t; e.v = v; e.c = c;
    q.push_back(e);
  endtask

  initial begin
    #2;
    expect_out("reset_hold", 3'b111, 6'd32, 1'b1, 6'd32);
    @(posedge clock);
    #1 reset = 1'b1;

    step(1, 0, 0, 0, 0, 0, 0, 0); expect_out("after_reset", 3'b111, 6'd32, 1'b1, 6'd32);

    // Enable low: dispatch and retire both ignored
    step(0, 1, 1, 0, 1, 6'd9, 0, 0); expect_out("en_low", 3'b111, 6'd32, 1'b1, 6'd32);
    step(1, 0, 0, 0, 0, 0, 0, 0);    expect_out("en_low_after", 3'b101, 6'd32, 1'b1, 6'd32);

    // Three pops
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pop0", 3'b111, 6'd32, 1'b1, 6'd32);
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pop1", 3'b101, 6'd33, 1'b1, 6'd31);
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pop2", 3'b101, 6'd34, 1'b1, 6'd30);

    // Drain the remaining 29 tags
    for (int i = 0; i < 29; i++) begin
      step(1, 1, 1, 0, 0, 0, 0, 0);
      expect_out("drain", 3'b111, 6'(35 + i), 1'b1, 6'(29 - i));
    end
    step(1, 1, 1, 0, 0, 0, 0, 0);      expect_out("empty_dispatch", 3'b110, 6'd0, 1'b0, 6'd0);
    step(1, 1, 1, 0, 1, 6'd5, 0, 0);   expect_out("empty_push_nobypass", 3'b110, 6'd0, 1'b0, 6'd0);
    step(1, 0, 0, 0, 0, 0, 0, 0);      expect_out("pushed_visible", 3'b111, 6'd5, 1'b1, 6'd1);

    // Refill to count 10 with tags 10..18
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, 0, 1, 6'(10 + k), 0, 0);
      expect_out("fill", 3'b110, 6'd0, 1'b1, 6'(1 + k));
    end
    step(1, 1, 1, 0, 1, 6'd20, 0, 0); expect_out("pop_push_same", 3'b101, 6'd5, 1'b1, 6'd10);

    // Advance head to 4, take a branch snapshot at ROB entry 2, then 3 more pops
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pre_branch0", 3'b101, 6'd10, 1'b1, 6'd10);
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pre_branch1", 3'b101, 6'd11, 1'b1, 6'd9);
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("pre_branch2", 3'b101, 6'd12, 1'b1, 6'd8);
    step(1, 1, 0, 2, 0, 0, 0, 0); expect_out("branch_nodest", 3'b101, 6'd13, 1'b1, 6'd7);
    step(1, 1, 1, 3, 0, 0, 0, 0); expect_out("spec_pop0", 3'b101, 6'd13, 1'b1, 6'd7);
    step(1, 1, 1, 4, 0, 0, 0, 0); expect_out("spec_pop1", 3'b101, 6'd14, 1'b1, 6'd6);
    step(1, 1, 1, 5, 0, 0, 0, 0); expect_out("spec_pop2", 3'b101, 6'd15, 1'b1, 6'd5);
    step(1, 0, 0, 0, 1, 6'd21, 1, 2); expect_out("rollback_push", 3'b101, 6'd16, 1'b1, 6'd4);

    // Snapshots at entries 5 (head 5) and 6 (head 6)
    step(1, 1, 1, 5, 0, 0, 0, 0); expect_out("restored", 3'b101, 6'd13, 1'b1, 6'd8);
    step(1, 1, 1, 6, 0, 0, 0, 0); expect_out("post_rb_pop", 3'b101, 6'd14, 1'b1, 6'd7);
    // Rollback to entry 5 while a dispatch targets entry 2: no pop, no snapshot write
    step(1, 1, 1, 2, 0, 0, 1, 5); expect_out("rb_with_dispatch", 3'b101, 6'd15, 1'b1, 6'd6);
    step(1, 0, 0, 0, 0, 0, 1, 2); expect_out("rb_no_pop", 3'b101, 6'd14, 1'b1, 6'd7);

    // Head back at 4 via untouched snapshot 2; drain to confirm pushed tags at the tail
    begin
      logic [5:0] tags [8];
      tags = '{6'd13, 6'd14, 6'd15, 6'd16, 6'd17, 6'd18, 6'd20, 6'd21};
      for (int i = 0; i < 8; i++) begin
        step(1, 1, 1, 0, 0, 0, 0, 0);
        expect_out("final_drain", 3'b111, tags[i], 1'b1, 6'(8 - i));
      end
    end
    step(1, 0, 0, 0, 1, 6'd7, 0, 0); expect_out("drained", 3'b110, 6'd0, 1'b0, 6'd0);
    step(1, 1, 1, 0, 1, 6'd8, 0, 0); expect_out("burst", 3'b101, 6'd7, 1'b1, 6'd1);

    // Asynchronous reset mid-burst
    step(1, 1, 1, 0, 1, 6'd9, 0, 0);
    #1 reset = 1'b0;
    expect_out("async_reset", 3'b111, 6'd32, 1'b1, 6'd32);
    @(posedge clock);
    #1;
    reset = 1'b1;
    dispatch_en = 1'b0; dest_valid = 1'b0; retire_en = 1'b0; retire_dest_valid = 1'b0;
    step(1, 1, 1, 0, 0, 0, 0, 0); expect_out("post_reset_pop", 3'b111, 6'd32, 1'b1, 6'd32);
    step(1, 0, 0, 0, 0, 0, 0, 0); expect_out("post_reset_next", 3'b101, 6'd33, 1'b1, 6'd31);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
